// File: rtl/gmac_ctrl_pkg.sv
// Shared definitions for the GMAC transmit arbiter.
// Holds the controller state encoding, default parameter values and a
// saturating counter helper used for the event counters.
package gmac_ctrl_pkg;

  localparam int unsigned CONFIRM_TIMEOUT_DEF = 1000;
  localparam int unsigned MAX_FRAME_DEF       = 1472;
  localparam int unsigned IDLE_GAP_DEF        = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    GRANT = 3'd2,
    XFER  = 3'd3,
    DRAIN = 3'd4,
    GAP   = 3'd5
  } state_e;

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   req0_i, req1_i  request levels
//   upd_i           load the round-robin pointer with upd_sel_i
//   upd_sel_i       source that was just served
//   sel_o           selected source (valid when valid_o)
//   valid_o         at least one request present
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_i,
  input  logic req1_i,
  input  logic upd_i,
  input  logic upd_sel_i,
  output logic sel_o,
  output logic valid_o
);

  logic last_q;

  // Pointer resets to 1 so source 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (upd_i) begin
      last_q <= upd_sel_i;
    end
  end

  // Single requester wins; on a tie the source not served last wins.
  always_comb begin
    valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      sel_o = ~last_q;
    end else begin
      sel_o = req1_i;
    end
  end

endmodule

// File: rtl/gmac_tx_arbiter.sv
// Shares the GMAC transmit channel between two frame sources.
// Round-robin arbitration, MAC request/confirm handshake with timeout,
// one frame per grant forwarded with one cycle of registered delay,
// truncation at MAX_FRAME bytes and an idle gap after each frame/timeout.
// Ports:
//   CLK, RST_N                       clock, async active-low reset
//   Req0/1, Grant0/1                 source request / grant levels
//   Val0/1, SoF0/1, EoF0/1, Data0/1  source byte streams
//   ValIn0, SoFIn0, EoFIn0, DataIn0  registered byte stream to the MAC
//   ReqIn0, ReqConfirm               MAC transmit request handshake
//   Busy                             controller not idle
//   TimeoutCnt, OversizeCnt          saturating event counters
module gmac_tx_arbiter
  import gmac_ctrl_pkg::*;
#(
  parameter int unsigned CONFIRM_TIMEOUT = CONFIRM_TIMEOUT_DEF,
  parameter int unsigned MAX_FRAME       = MAX_FRAME_DEF,
  parameter int unsigned IDLE_GAP        = IDLE_GAP_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Req0,
  input  logic        Req1,
  output logic        Grant0,
  output logic        Grant1,
  input  logic        Val0,
  input  logic        Val1,
  input  logic        SoF0,
  input  logic        SoF1,
  input  logic        EoF0,
  input  logic        EoF1,
  input  logic [7:0]  Data0,
  input  logic [7:0]  Data1,
  output logic        ValIn0,
  output logic        SoFIn0,
  output logic        EoFIn0,
  output logic [7:0]  DataIn0,
  output logic        ReqIn0,
  input  logic        ReqConfirm,
  output logic        Busy,
  output logic [15:0] TimeoutCnt,
  output logic [15:0] OversizeCnt
);

  localparam int unsigned WAIT_W = $clog2(CONFIRM_TIMEOUT);
  localparam int unsigned CNT_W  = $clog2(MAX_FRAME + 1);
  localparam int unsigned GAP_W  = $clog2(IDLE_GAP + 1);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CONFIRM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_FRAME);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(IDLE_GAP - 1);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  byte_q, byte_d, byte_inc;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              grant0_q, grant0_d, grant1_q, grant1_d;
  logic              req_q, req_d, busy_q, busy_d;
  logic              val_q, val_d, sof_q, sof_d, eof_q, eof_d;
  logic [7:0]        data_q, data_d;
  logic [15:0]       to_q, to_d, os_q, os_d;

  logic       arb_sel, arb_valid, arb_upd;
  logic       s_val, s_sof, s_eof;
  logic [7:0] s_data;

  rr_arb2 u_rr_arb2 (
    .clk       (CLK),
    .rst_n     (RST_N),
    .req0_i    (Req0),
    .req1_i    (Req1),
    .upd_i     (arb_upd),
    .upd_sel_i (sel_q),
    .sel_o     (arb_sel),
    .valid_o   (arb_valid)
  );

  // Only the selected source is ever observed.
  always_comb begin
    s_val  = sel_q ? Val1  : Val0;
    s_sof  = sel_q ? SoF1  : SoF0;
    s_eof  = sel_q ? EoF1  : EoF0;
    s_data = sel_q ? Data1 : Data0;
  end

  assign byte_inc = byte_q + CNT_W'(1);

  // State register and all registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      wait_q   <= '0;
      byte_q   <= '0;
      gap_q    <= '0;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      val_q    <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      data_q   <= 8'h00;
      to_q     <= 16'h0000;
      os_q     <= 16'h0000;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      wait_q   <= wait_d;
      byte_q   <= byte_d;
      gap_q    <= gap_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      val_q    <= val_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      data_q   <= data_d;
      to_q     <= to_d;
      os_q     <= os_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wait_d  = wait_q;
    byte_d  = byte_q;
    gap_d   = gap_q;
    val_d   = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    data_d  = data_q;
    to_d    = to_q;
    os_d    = os_q;
    arb_upd = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          sel_d   = arb_sel;
          wait_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // Confirm beats a timeout landing on the same cycle.
        if (ReqConfirm) begin
          state_d = GRANT;
        end else if (wait_q == WAIT_LAST) begin
          to_d    = sat_inc16(to_q);
          arb_upd = 1'b1;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      GRANT: begin
        // Bytes ahead of the first SoF are dropped.
        if (s_val && s_sof) begin
          val_d  = 1'b1;
          sof_d  = 1'b1;
          data_d = s_data;
          byte_d = CNT_W'(1);
          if (s_eof) begin
            eof_d   = 1'b1;
            arb_upd = 1'b1;
            gap_d   = '0;
            state_d = GAP;
          end else begin
            state_d = XFER;
          end
        end
      end
      XFER: begin
        if (s_val) begin
          val_d  = 1'b1;
          data_d = s_data;
          byte_d = byte_inc;
          if (s_eof) begin
            eof_d   = 1'b1;
            arb_upd = 1'b1;
            gap_d   = '0;
            state_d = GAP;
          end else if (byte_inc == CNT_MAX) begin
            eof_d   = 1'b1;
            os_d    = sat_inc16(os_q);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Swallow the rest of a truncated frame up to the source's EoF.
        if (s_val && s_eof) begin
          arb_upd = 1'b1;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    req_d    = (state_d == REQ);
    grant0_d = (state_d inside {GRANT, XFER, DRAIN}) && !sel_d;
    grant1_d = (state_d inside {GRANT, XFER, DRAIN}) &&  sel_d;
    busy_d   = (state_d != IDLE);
  end

  assign Grant0      = grant0_q;
  assign Grant1      = grant1_q;
  assign ReqIn0      = req_q;
  assign Busy        = busy_q;
  assign ValIn0      = val_q;
  assign SoFIn0      = sof_q;
  assign EoFIn0      = eof_q;
  assign DataIn0     = data_q;
  assign TimeoutCnt  = to_q;
  assign OversizeCnt = os_q;

endmodule

// File: tb/tb_gmac_tx_arbiter.sv
// Randomised transaction-level bench for gmac_tx_arbiter.
// The bench plays both sources and the MAC; a frame-level model predicts
// the winner, handshake length, forwarded bytes, gap length and counters.
module tb_gmac_tx_arbiter;

  localparam int unsigned CT = 20;
  localparam int unsigned MF = 64;
  localparam int unsigned IG = 12;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic        Grant0, Grant1;
  logic        Val0 = 1'b0, Val1 = 1'b0, SoF0 = 1'b0, SoF1 = 1'b0;
  logic        EoF0 = 1'b0, EoF1 = 1'b0;
  logic [7:0]  Data0 = 8'h00, Data1 = 8'h00;
  logic        ValIn0, SoFIn0, EoFIn0, ReqIn0, Busy;
  logic [7:0]  DataIn0;
  logic        ReqConfirm = 1'b0;
  logic [15:0] TimeoutCnt, OversizeCnt;

  always #5 CLK = ~CLK;

  gmac_tx_arbiter #(
    .CONFIRM_TIMEOUT (CT),
    .MAX_FRAME       (MF),
    .IDLE_GAP        (IG)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .Req0        (Req0),
    .Req1        (Req1),
    .Grant0      (Grant0),
    .Grant1      (Grant1),
    .Val0        (Val0),
    .Val1        (Val1),
    .SoF0        (SoF0),
    .SoF1        (SoF1),
    .EoF0        (EoF0),
    .EoF1        (EoF1),
    .Data0       (Data0),
    .Data1       (Data1),
    .ValIn0      (ValIn0),
    .SoFIn0      (SoFIn0),
    .EoFIn0      (EoFIn0),
    .DataIn0     (DataIn0),
    .ReqIn0      (ReqIn0),
    .ReqConfirm  (ReqConfirm),
    .Busy        (Busy),
    .TimeoutCnt  (TimeoutCnt),
    .OversizeCnt (OversizeCnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int m_last = 1;
  int m_to   = 0;
  int m_os   = 0;

  logic [9:0] mon_q[$];
  bit         both_seen;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next sampling point and record MAC-side activity.
  task automatic tick();
    @(negedge CLK);
    if (Grant0 && Grant1) both_seen = 1'b1;
    if (ValIn0) mon_q.push_back({SoFIn0, EoFIn0, DataIn0});
  endtask

  task automatic set_src(input int s, input logic v, input logic so, input logic eo,
                         input logic [7:0] d);
    if (s == 0) begin
      Val0 = v; SoF0 = so; EoF0 = eo; Data0 = d;
    end else begin
      Val1 = v; SoF1 = so; EoF1 = eo; Data1 = d;
    end
  endtask

  task automatic noise(input int s);
    set_src(s, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
  endtask

  function automatic logic [63:0] out_vec();
    return {25'd0, Grant1, Grant0, ValIn0, SoFIn0, EoFIn0, ReqIn0, Busy,
            DataIn0, TimeoutCnt, OversizeCnt};
  endfunction

  // One request: confirm after d cycles of ReqIn0 (d < 0: never), frame of
  // len bytes preceded by junk discarded bytes; abort_at > 0 resets the DUT
  // right after that many frame bytes have been taken.
  task automatic run_frame(input bit r0, input bit r1, input int d, input int len,
                           input int junk, input int abort_at);
    int         win, cnt, w, gapc, n, exp_g;
    bit         to, grant_bad, last;
    logic [7:0] bytes[$];
    logic [9:0] ev;

    win = (r0 && r1) ? ((m_last == 0) ? 1 : 0) : (r1 ? 1 : 0);
    exp_g = (win == 1) ? 2 : 1;
    w = 0;
    while (Busy && w < 400) begin tick(); w++; end
    mon_q.delete();
    both_seen = 1'b0;

    Req0 = r0; Req1 = r1;
    noise(0); noise(1);
    w = 0;
    do begin tick(); noise(0); noise(1); w++; end while (!ReqIn0 && w < 4);
    check_eq("req_rise", ReqIn0, 1);
    Req0 = 1'b0; Req1 = 1'b0;

    cnt = 0;
    while (ReqIn0 && cnt < int'(CT) + 4) begin
      ReqConfirm = (cnt == d);
      cnt++;
      noise(0); noise(1);
      tick();
    end
    ReqConfirm = 1'b0;
    to = (d < 0) || (d >= int'(CT));
    check_eq("req_len", cnt, to ? CT : d + 1);

    if (to) begin
      m_to++;
      m_last = win;
      check_eq("timeout_cnt", TimeoutCnt, m_to);
      check_eq("grant_on_timeout", {Grant1, Grant0}, 0);
    end else begin
      check_eq("grant_sel", {Grant1, Grant0}, exp_g);
      grant_bad = 1'b0;
      for (int i = 0; i < junk; i++) begin
        set_src(win, 1'b1, 1'b0, 1'($urandom), 8'($urandom));
        noise(1 - win);
        tick();
        if ({Grant1, Grant0} != 2'(exp_g)) grant_bad = 1'b1;
      end
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(3) == 0) begin
          set_src(win, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
          noise(1 - win);
          tick();
          if ({Grant1, Grant0} != 2'(exp_g)) grant_bad = 1'b1;
        end
        bytes.push_back(8'($urandom));
        last = (i == len - 1);
        set_src(win, 1'b1, (i == 0), last, bytes[i]);
        noise(1 - win);
        tick();
        if (!last && {Grant1, Grant0} != 2'(exp_g)) grant_bad = 1'b1;
        if (abort_at > 0 && i + 1 == abort_at) begin
          RST_N = 1'b0;
          #1;
          check_eq("abort_outputs", out_vec(), 64'd0);
          set_src(0, 0, 0, 0, 0); set_src(1, 0, 0, 0, 0);
          tick(); tick();
          RST_N = 1'b1;
          m_last = 1; m_to = 0; m_os = 0;
          return;
        end
      end
      set_src(win, 1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("grant_held", grant_bad, 0);
      check_eq("grant_drop", {Grant1, Grant0}, 0);
      m_last = win;
      if (len > int'(MF)) m_os++;
    end

    gapc = 0;
    while (Busy && gapc < int'(IG) + 8) begin
      gapc++;
      noise(0); noise(1);
      tick();
    end
    check_eq("gap_len", gapc, IG);
    check_eq("grant_onehot", both_seen, 0);
    check_eq("oversize_cnt", OversizeCnt, m_os);
    check_eq("timeout_cnt_end", TimeoutCnt, m_to);

    n = to ? 0 : ((len > int'(MF)) ? int'(MF) : len);
    check_eq("frame_len", mon_q.size(), n);
    for (int i = 0; i < n && i < mon_q.size(); i++) begin
      ev = {1'(i == 0), 1'(i == n - 1), bytes[i]};
      check_eq("frame_byte", mon_q[i], ev);
    end
    set_src(0, 0, 0, 0, 0); set_src(1, 0, 0, 0, 0);
  endtask

  initial begin
    #1;
    check_eq("reset_outputs", out_vec(), 64'd0);
    tick(); tick();
    RST_N = 1'b1;
    tick();
    check_eq("idle_after_reset", {Busy, ReqIn0, Grant1, Grant0}, 0);

    run_frame(1, 0, 3, 64, 0, 0);           // confirm after 3, frame of exactly MAX
    for (int k = 0; k < 4; k++)
      run_frame(1, 1, $urandom_range(4), 10, 0, 0);
    run_frame(1, 1, -1, 10, 0, 0);          // confirm never arrives
    run_frame(1, 1, 1, 10, 0, 0);           // the other source goes next
    run_frame(0, 1, CT - 1, 12, 0, 0);      // confirm on the timeout cycle
    run_frame(1, 0, 0, MF + 26, 0, 0);      // truncated frame
    run_frame(0, 1, 2, 1, 3, 0);            // junk then one-byte frame
    run_frame(1, 1, 2, 40, 0, 20);          // reset mid-frame
    run_frame(1, 1, 1, 8, 0, 0);            // source 0 first after reset

    for (int k = 0; k < 30; k++) begin
      int r, d, len;
      r = $urandom_range(1, 3);
      case ($urandom_range(9))
        0:       d = -1;
        1:       d = CT - 1;
        default: d = $urandom_range(5);
      endcase
      len = $urandom_range(1, MF + 24);
      run_frame(r[0], r[1], d, len, $urandom_range(3), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
